seg_readback_decoder: RTL and testbench

- Decodes the pair of 9-bit seven-segment drive buses produced by the hex counter display path back into an 8-bit value.
- Each pattern must hold stable for a programmable number of cycles before it is accepted, so display glitches never produce a value.
- Flags and counts illegal segment patterns.
- Sits on the board-level loopback/monitor path, observing the same segment buses that drive the LEDs.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seg_readback_decoder_if.sv | 20 ++
 rtl/seg_digit_decode.sv | 24 ++
 rtl/seg_readback_decoder.sv | 131 +++++++++++++
 tb/tb_seg_readback_decoder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared segment-display definitions: digit pattern table, blank code and the
// readback decoder state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index is the nibble value; bit0 = segment a, active-high.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
    7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    EMPTY,
    SETTLING,
    STABLE,
    ERROR
  } seg_state_e;

endpackage

// File: rtl/seg_readback_decoder_if.sv
// Segment bus observation port and decoded-value results of the readback decoder.
interface seg_readback_decoder_if;
  logic [8:0] seg_led_1;
  logic [8:0] seg_led_2;
  logic [7:0] value;
  logic       value_valid;
  logic       value_strobe;
  logic       pattern_err;
  logic [7:0] err_count;

  modport master (
    output seg_led_1, seg_led_2,
    input  value, value_valid, value_strobe, pattern_err, err_count
  );

  modport slave (
    input  seg_led_1, seg_led_2,
    output value, value_valid, value_strobe, pattern_err, err_count
  );
endinterface

// File: rtl/seg_digit_decode.sv
// Combinational seven-segment pattern to nibble decoder with legal/blank flags.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  always_comb begin
    nibble = '0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_PATTERNS[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

  assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg_readback_decoder.sv
// Debounced readback of the two-digit hex display: samples both segment buses,
// waits for STABLE_CYCLES identical samples, then commits a value or an error.
module seg_readback_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  seg_readback_decoder_if.slave bus
);

  // state      | meaning
  // EMPTY      | reset, or both digits settled blank
  // SETTLING   | sample changed, waiting for a stable pair
  // STABLE     | legal pair committed, value valid
  // ERROR      | illegal pair committed, pattern_err raised

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

  logic [13:0]   sample_in;
  logic [13:0]   sample_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg_q;
  logic          same;
  logic          commit;
  logic          unused_hi;

  logic [3:0]    nib_hi, nib_lo;
  logic          legal_hi, legal_lo, blank_hi, blank_lo;

  seg_state_e    state_q, state_d;
  seg_state_e    last_q, last_d;
  logic [7:0]    value_q, value_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  assign sample_in = {bus.seg_led_1[6:0], bus.seg_led_2[6:0]};
  assign unused_hi = ^{bus.seg_led_1[8:7], bus.seg_led_2[8:7]};
  assign same      = (sample_in == sample_q);

  always_comb begin
    cnt_d = '0;
    if (same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
  end

  // Commit only on the edge the counter first reaches the limit.
  assign commit = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
    end else begin
      sample_q <= sample_in;
      cnt_q    <= cnt_d;
      chg_q    <= !same;
    end
  end

  seg_digit_decode u_dec_hi (
    .pattern (sample_q[13:7]),
    .nibble  (nib_hi),
    .legal   (legal_hi),
    .blank   (blank_hi)
  );

  seg_digit_decode u_dec_lo (
    .pattern (sample_q[6:0]),
    .nibble  (nib_lo),
    .legal   (legal_lo),
    .blank   (blank_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      last_q    <= EMPTY;
      value_q   <= 8'h00;
      strobe_q  <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      value_q   <= value_d;
      strobe_q  <= strobe_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    value_d   = value_q;
    strobe_d  = 1'b0;
    err_cnt_d = err_cnt_q;
    if (commit) begin
      if (blank_hi && blank_lo) begin
        state_d = EMPTY;
        last_d  = EMPTY;
      end else if (legal_hi && legal_lo) begin
        state_d = STABLE;
        last_d  = STABLE;
        value_d = {nib_hi, nib_lo};
        // Re-settling onto the same legal byte is silent.
        if (({nib_hi, nib_lo} != value_q) || (last_q != STABLE)) begin
          strobe_d = 1'b1;
        end
      end else begin
        state_d = ERROR;
        last_d  = ERROR;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end else if (chg_q) begin
      state_d = SETTLING;
    end
  end

  assign bus.value        = value_q;
  assign bus.value_valid  = (state_q == STABLE);
  assign bus.value_strobe = strobe_q;
  assign bus.pattern_err  = (state_q == ERROR);
  assign bus.err_count    = err_cnt_q;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Directed bench for seg_readback_decoder: default depth instance plus a
// STABLE_CYCLES=1 instance observing the same buses.
module tb_seg_readback_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec  = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  seg_readback_decoder_if bus ();
  seg_readback_decoder_if bus1 ();

  assign bus1.seg_led_1 = bus.seg_led_1;
  assign bus1.seg_led_2 = bus.seg_led_2;

  seg_readback_decoder #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seg_readback_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Upper bits [8:7] carry junk to confirm they are ignored.
  task automatic drive(input logic [6:0] hi, input logic [6:0] lo);
    bus.seg_led_1 = {2'b10, hi};
    bus.seg_led_2 = {2'b01, lo};
  endtask

  // Steps four edges with no strobe, then the commit edge; returns nothing.
  task automatic settle(input string tag, input logic exp_strobe);
    for (int k = 0; k < 4; k++) begin
      step();
      chk({tag, "_nostrobe"}, 8'(bus.value_strobe), 8'h00);
    end
    step();
    chk({tag, "_strobe"}, 8'(bus.value_strobe), 8'(exp_strobe));
  endtask

  initial begin
    drive(7'h3f, 7'h3f);
    step();
    step();
    chk("rst_value", bus.value, 8'h00);
    chk("rst_valid", 8'(bus.value_valid), 8'h00);
    chk("rst_strobe", 8'(bus.value_strobe), 8'h00);
    chk("rst_perr", 8'(bus.pattern_err), 8'h00);
    chk("rst_errcnt", bus.err_count, 8'h00);

    // Reset release: N=4 commits on the 5th edge, N=1 on the 2nd.
    rst = 1'b0;
    step();
    chk("n1_e1_strobe", 8'(bus1.value_strobe), 8'h00);
    step();
    chk("n1_e2_strobe", 8'(bus1.value_strobe), 8'h01);
    chk("n1_e2_valid", 8'(bus1.value_valid), 8'h01);
    step();
    chk("n1_e3_strobe", 8'(bus1.value_strobe), 8'h00);
    step();
    chk("rel_e4_strobe", 8'(bus.value_strobe), 8'h00);
    step();
    chk("rel_e5_strobe", 8'(bus.value_strobe), 8'h01);
    chk("rel_value", bus.value, 8'h00);
    chk("rel_valid", 8'(bus.value_valid), 8'h01);
    step();
    chk("rel_strobe_once", 8'(bus.value_strobe), 8'h00);
    chk("rel_valid_hold", 8'(bus.value_valid), 8'h01);

    // 3f/06 -> 01
    drive(7'h3f, 7'h06);
    step();
    chk("c01_e0_valid", 8'(bus.value_valid), 8'h01);
    step();
    chk("c01_e1_valid", 8'(bus.value_valid), 8'h00);
    chk("c01_n1_strobe", 8'(bus1.value_strobe), 8'h01);
    chk("c01_n1_value", bus1.value, 8'h01);
    step();
    step();
    chk("c01_e3_strobe", 8'(bus.value_strobe), 8'h00);
    step();
    chk("c01_e4_strobe", 8'(bus.value_strobe), 8'h01);
    chk("c01_value", bus.value, 8'h01);
    step();

    // 7c/71 -> BF
    drive(7'h7c, 7'h71);
    step();
    chk("cbf_e0_valid", 8'(bus.value_valid), 8'h01);
    step();
    chk("cbf_e1_valid", 8'(bus.value_valid), 8'h00);
    chk("cbf_e1_value", bus.value, 8'h01);
    step();
    step();
    chk("cbf_e3_strobe", 8'(bus.value_strobe), 8'h00);
    step();
    chk("cbf_e4_strobe", 8'(bus.value_strobe), 8'h01);
    chk("cbf_value", bus.value, 8'hBF);
    chk("cbf_valid", 8'(bus.value_valid), 8'h01);

    // Settle 23, then two-cycle glitch back to the same pair.
    drive(7'h5b, 7'h4f);
    settle("c23", 1'b1);
    chk("c23_value", bus.value, 8'h23);
    drive(7'h7f, 7'h4f);
    step();
    chk("gl_ek_valid", 8'(bus.value_valid), 8'h01);
    step();
    chk("gl_ek1_valid", 8'(bus.value_valid), 8'h00);
    drive(7'h5b, 7'h4f);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("gl_settle_valid", 8'(bus.value_valid), 8'h00);
      chk("gl_settle_strobe", 8'(bus.value_strobe), 8'h00);
    end
    step();
    chk("gl_valid", 8'(bus.value_valid), 8'h01);
    chk("gl_strobe", 8'(bus.value_strobe), 8'h00);
    chk("gl_value", bus.value, 8'h23);

    // Illegal low digit.
    drive(7'h3f, 7'h01);
    settle("ill", 1'b0);
    chk("ill_perr", 8'(bus.pattern_err), 8'h01);
    chk("ill_errcnt", bus.err_count, 8'h01);
    chk("ill_value", bus.value, 8'h23);
    chk("ill_valid", 8'(bus.value_valid), 8'h00);
    drive(7'h3f, 7'h3f);
    step();
    chk("rec_e0_perr", 8'(bus.pattern_err), 8'h01);
    step();
    chk("rec_e1_perr", 8'(bus.pattern_err), 8'h00);
    step();
    step();
    step();
    chk("rec_strobe", 8'(bus.value_strobe), 8'h01);
    chk("rec_value", bus.value, 8'h00);

    // Blank pair -> EMPTY, value held.
    drive(7'h5e, 7'h39);
    settle("cdc", 1'b1);
    drive(7'h00, 7'h00);
    settle("blank", 1'b0);
    chk("blank_valid", 8'(bus.value_valid), 8'h00);
    chk("blank_perr", 8'(bus.pattern_err), 8'h00);
    chk("blank_errcnt", bus.err_count, 8'h01);
    chk("blank_value", bus.value, 8'hDC);

    // One blank + one legal digit is illegal; then saturate the counter.
    drive(7'h00, 7'h06);
    for (int k = 0; k < 5; k++) step();
    chk("half_blank_perr", 8'(bus.pattern_err), 8'h01);
    chk("half_blank_errcnt", bus.err_count, 8'h02);
    for (int i = 0; i < 300; i++) begin
      drive(7'h3f, 7'h01);
      for (int k = 0; k < 5; k++) step();
      drive(7'h00, 7'h00);
      for (int k = 0; k < 5; k++) step();
      if (i == 100) chk("sat_mid_errcnt", bus.err_count, 8'd103);
    end
    chk("sat_errcnt", bus.err_count, 8'hFF);
    chk("sat_perr", 8'(bus.pattern_err), 8'h00);

    // Async reset mid-settle.
    drive(7'h7c, 7'h71);
    settle("pre_rst", 1'b1);
    chk("pre_rst_value", bus.value, 8'hBF);
    drive(7'h3f, 7'h06);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_value", bus.value, 8'h00);
    chk("arst_valid", 8'(bus.value_valid), 8'h00);
    chk("arst_errcnt", bus.err_count, 8'h00);
    chk("arst_perr", 8'(bus.pattern_err), 8'h00);
    chk("arst_strobe", 8'(bus.value_strobe), 8'h00);
    step();
    step();
    chk("arst_hold_strobe", 8'(bus.value_strobe), 8'h00);
    #2;
    rst = 1'b0;
    settle("post_rst", 1'b1);
    chk("post_rst_value", bus.value, 8'h01);
    chk("post_rst_valid", 8'(bus.value_valid), 8'h01);
    step();
    chk("post_rst_strobe_once", 8'(bus.value_strobe), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
